// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding one FIFO write port from NREQ requesters.
// Define FIFO_WR_ARB_BURST_EN to let a granted requester keep the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int NREQ        = 4,
    parameter int WRITE_WIDTH = 18,
    parameter int BURST_LEN   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WRITE_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]             ack,
    input  logic                        full,
    input  logic                        afull,
    output logic                        we,
    output logic [WRITE_WIDTH-1:0]      wdata,
    output logic [2:0]                  gnt_id,
    output logic [15:0]                 wr_count
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ out of range");
    end
    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst
        $error("BURST_LEN out of range");
    end

    logic                   r_we;
    logic [WRITE_WIDTH-1:0] r_wdata;
    logic [2:0]             r_gnt_id;
    logic [15:0]            r_wr_count;
    logic [2:0]             r_ptr;

    logic                   w_issue_ok;
    logic                   w_found;
    logic [2:0]             w_sel;
    logic [3:0]             w_idx;
    logic                   w_accept;
    logic [WRITE_WIDTH-1:0] w_sel_data;
    logic [2:0]             w_ptr_nxt;
    logic                   w_burst_hold;
    logic [2:0]             w_hold_id;

    // One slot left and a write already in flight counts as full.
    assign w_issue_ok = !full && !(r_we && afull);

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = '0;
        if (w_burst_hold) begin
            w_found = 1'b1;
            w_sel   = w_hold_id;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = {1'b0, r_ptr} + 4'(k);
                if (w_idx >= 4'(NREQ)) begin
                    w_idx = w_idx - 4'(NREQ);
                end
                for (int j = 0; j < NREQ; j++) begin
                    if (!w_found && w_idx == 4'(j) && req[j]) begin
                        w_found = 1'b1;
                        w_sel   = 3'(j);
                    end
                end
            end
        end
    end

    // Gating with reset keeps ack low for the whole reset window.
    assign w_accept = w_found && w_issue_ok && reset;

    always_comb begin
        ack        = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = w_accept && (w_sel == 3'(i));
            if (w_sel == 3'(i)) begin
                w_sel_data = req_data[i*WRITE_WIDTH +: WRITE_WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_sel == 3'(NREQ-1)) ? 3'd0 : w_sel + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_gnt_id   <= '0;
            r_wr_count <= '0;
            r_ptr      <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_wdata    <= w_sel_data;
                r_gnt_id   <= w_sel;
                r_wr_count <= r_wr_count + 16'd1;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    // state   | meaning
    // S_IDLE  | no owner; round-robin search from r_ptr
    // S_BURST | r_burst_id owns the port while it requests and beats remain
    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [2:0] r_burst_id, w_burst_id_nxt;
    logic       w_owner_req;

    always_comb begin
        w_owner_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_burst_id == 3'(i)) begin
                w_owner_req = req[i];
            end
        end
    end

    assign w_burst_hold = (r_state == S_BURST) && w_owner_req;
    assign w_hold_id    = r_burst_id;

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        w_burst_id_nxt  = r_burst_id;
        if (w_accept) begin
            if (w_burst_hold) begin
                if (r_burst_cnt + 5'd1 == 5'(BURST_LEN)) begin
                    w_state_nxt     = S_IDLE;
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_burst_cnt_nxt = r_burst_cnt + 5'd1;
                end
            end else if (BURST_LEN > 1) begin
                w_state_nxt     = S_BURST;
                w_burst_cnt_nxt = 5'd1;
                w_burst_id_nxt  = w_sel;
            end else begin
                w_state_nxt     = S_IDLE;
                w_burst_cnt_nxt = '0;
            end
        end else if (r_state == S_BURST && !w_owner_req) begin
            w_state_nxt     = S_IDLE;
            w_burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_burst_id  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_burst_id  <= w_burst_id_nxt;
        end
    end
`else
    assign w_burst_hold = 1'b0;
    assign w_hold_id    = 3'd0;
`endif

    assign we       = r_we;
    assign wdata    = r_wdata;
    assign gnt_id   = r_gnt_id;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a queue-free grant-order model.
// Builds with or without FIFO_WR_ARB_BURST_EN; the model follows the same macro.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 18;
    localparam int BL   = 4;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int MODEL_BL = BL;
`else
    localparam int MODEL_BL = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              full, afull;
    logic              we;
    logic [W-1:0]      wdata;
    logic [2:0]        gnt_id;
    logic [15:0]       wr_count;

    fifo_wr_arbiter #(.NREQ(NREQ), .WRITE_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .full(full), .afull(afull), .we(we), .wdata(wdata), .gnt_id(gnt_id),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model state: next search start, burst owner (-1 none), beats taken by owner
    int          nxt, own, beats;
    logic        exp_we;
    logic [W-1:0] exp_wd;
    logic [2:0]  exp_g;
    logic [15:0] exp_cnt;
    logic [W-1:0] dat [NREQ];
    logic [NREQ-1:0] pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_init();
        nxt = 0; own = -1; beats = 0;
        exp_we = 1'b0; exp_wd = '0; exp_g = '0; exp_cnt = '0;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] rq, input bit ok);
        if (!ok) return -1;
        if (own >= 0 && rq[own]) return own;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (nxt + k) % NREQ;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic step(input logic [NREQ-1:0] rq, input logic f, input logic af, output int g);
        logic [NREQ-1:0] ea;
        req = rq; full = f; afull = af;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = dat[i];
        #1;
        g  = pick(rq, !f && !(exp_we && af));
        ea = '0;
        if (g >= 0) ea[g] = 1'b1;
        chk("ack", 32'(ack), 32'(ea));
        if (g >= 0) begin
            exp_we = 1'b1; exp_wd = dat[g]; exp_g = 3'(g); exp_cnt = exp_cnt + 16'd1;
            if (own == g) begin
                beats++;
                if (beats == MODEL_BL) own = -1;
            end else if (MODEL_BL > 1) begin
                own = g; beats = 1;
            end else begin
                own = -1;
            end
            nxt = (g + 1) % NREQ;
            dat[g] = W'($urandom);
        end else begin
            exp_we = 1'b0;
            if (own >= 0 && !rq[own]) own = -1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("we", 32'(we), 32'(exp_we));
        chk("wdata", 32'(wdata), 32'(exp_wd));
        chk("gnt_id", 32'(gnt_id), 32'(exp_g));
        chk("wr_count", 32'(wr_count), 32'(exp_cnt));
    endtask

    task automatic step_d(input logic [NREQ-1:0] rq, input logic f, input logic af);
        int g;
        step(rq, f, af, g);
    endtask

    // Reset is dropped while requests are live; everything must clear at once.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_gnt", 32'(gnt_id), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        model_init();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < NREQ; i++) dat[i] = W'($urandom);
        reset = 1'b0; req = '0; req_data = '0; full = 1'b0; afull = 1'b0;
        model_init();
        repeat (2) @(negedge clk);
        req = '1;
        do_reset();

        repeat (6) step_d(4'b1111, 1'b0, 1'b0);

        do_reset();
        repeat (10) step_d(4'b0011, 1'b0, 1'b0);

        repeat (5) step_d(4'b0100, 1'b1, 1'b0);
        step_d(4'b0100, 1'b0, 1'b0);
        step_d(4'b0000, 1'b0, 1'b0);

        step_d(4'b1111, 1'b0, 1'b0);
        step_d(4'b1111, 1'b0, 1'b1);
        step_d(4'b1111, 1'b0, 1'b1);
        step_d(4'b1111, 1'b0, 1'b1);

        do_reset();
        step_d(4'b1111, 1'b0, 1'b0);
        step_d(4'b1111, 1'b0, 1'b0);
        req = 4'b1111;
        do_reset();
        step_d(4'b1110, 1'b0, 1'b0);
        step_d(4'b1111, 1'b0, 1'b0);

        pend = '0;
        repeat (600) begin
            logic [NREQ-1:0] rq;
            for (int i = 0; i < NREQ; i++)
                rq[i] = pend[i] ? ($urandom_range(15) != 0) : 1'($urandom_range(1));
            step(rq, $urandom_range(4) == 0, $urandom_range(2) == 0, g);
            pend = rq;
            if (g >= 0) pend[g] = 1'b0;
        end

        reset = 1'b0;
        req = 4'b1111; full = 1'b0; afull = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("count_max", 32'(wr_count), 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("count_wrap", 32'(wr_count), 32'd0);
        chk("wrap_we", 32'(we), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
